fp_path_merge: RTL and testbench

Result-merge stage of the floating-point adder, opposite end of the operand-routing demux. Operands are steered to one of three datapath lanes (00, 01, 10) by a 2-bit path select; this block records each issued select in a tag FIFO and collects the lane results in issue order. It presents them as one registered valid/ready stream to the normalize/pack stage. Out-of-order lane completions are back-pressured until their turn.

---
 rtl/fp_add_pkg.sv | 21 ++
 rtl/fp_path_merge_tag_fifo.sv | 66 ++++++
 rtl/fp_path_merge.sv | 137 +++++++++++++
 tb/tb_fp_path_merge.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_add_pkg.sv
// fp_add_pkg: constants and types shared by the floating-point adder's
// operand-routing demux and its result-merge stage.
//   FP_W        result word width (sign + exponent + extended mantissa)
//   path_sel_t  2-bit datapath lane select
//   PATH_*      lane select encodings; PATH_BAD is not a valid lane
package fp_add_pkg;

  localparam int unsigned FP_W = 37;

  typedef logic [1:0] path_sel_t;

  localparam path_sel_t PATH_0   = 2'b00;
  localparam path_sel_t PATH_1   = 2'b01;
  localparam path_sel_t PATH_2   = 2'b10;
  localparam path_sel_t PATH_BAD = 2'b11;

  function automatic logic is_bad_path(input path_sel_t sel);
    return sel == PATH_BAD;
  endfunction

endpackage

// File: rtl/fp_path_merge_tag_fifo.sv
// tag_fifo: synchronous FIFO with full/empty/count flags, async active-high
// reset. Pushes while full and pops while empty are ignored.
//   clk, rst       clock, asynchronous active-high reset
//   push_i/wdata_i write strobe and data
//   pop_i          read strobe (rdata_o shows the head entry)
//   rdata_o        head entry, valid while empty_o is low
//   full_o/empty_o occupancy flags
//   count_o        number of stored entries, 0..DEPTH
module tag_fifo #(
  parameter int unsigned W     = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [W-1:0]               wdata_i,
  input  logic                       pop_i,
  output logic [W-1:0]               rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointers are log2(DEPTH) bits and wrap on their own (DEPTH is a power of two).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      count_q <= count_d;
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

endmodule

// File: rtl/fp_path_merge.sv
// fp_path_merge: result-merge stage of the FP adder. Records each issued lane
// select in a tag FIFO and collects lane results strictly in issue order,
// presenting them as one registered valid/ready stream.
//   clk, rst                      clock, asynchronous active-high reset
//   issue_valid/issue_sel         dispatch to lane issue_sel this cycle
//   issue_ready                   tag FIFO not full
//   rN_valid/rN_data/rN_ready     lane N result handshake (N = 0..2)
//   out_valid/out_data/out_sel    merged result and its producing lane
//   out_ready                     downstream accepts
//   err                           sticky: an issue with select 2'b11 was seen
module fp_path_merge
  import fp_add_pkg::*;
#(
  parameter int unsigned W     = FP_W,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         issue_valid,
  input  logic [1:0]   issue_sel,
  output logic         issue_ready,
  input  logic         r0_valid,
  input  logic [W-1:0] r0_data,
  output logic         r0_ready,
  input  logic         r1_valid,
  input  logic [W-1:0] r1_data,
  output logic         r1_ready,
  input  logic         r2_valid,
  input  logic [W-1:0] r2_data,
  output logic         r2_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic [1:0]   out_sel,
  input  logic         out_ready,
  output logic         err
);

  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  path_sel_t        head_sel;
  logic             push, pop, load_ok;
  logic             head_valid;
  logic [W-1:0]     head_data;

  logic             out_valid_q;
  logic [W-1:0]     out_data_q;
  path_sel_t        out_sel_q;
  logic             err_q;

  // issue_ready looks only at the registered count: a pop in the same cycle
  // does not free a slot for a push until the next cycle.
  assign issue_ready = !fifo_full;
  assign push        = issue_valid && !fifo_full && !is_bad_path(issue_sel);
  assign load_ok     = !out_valid_q || out_ready;

  // Only the lane named by the head tag may hand over a result.
  always_comb begin
    r0_ready   = 1'b0;
    r1_ready   = 1'b0;
    r2_ready   = 1'b0;
    head_valid = 1'b0;
    head_data  = '0;
    if (!fifo_empty) begin
      case (head_sel)
        PATH_0: begin
          r0_ready   = load_ok;
          head_valid = r0_valid;
          head_data  = r0_data;
        end
        PATH_1: begin
          r1_ready   = load_ok;
          head_valid = r1_valid;
          head_data  = r1_data;
        end
        PATH_2: begin
          r2_ready   = load_ok;
          head_valid = r2_valid;
          head_data  = r2_data;
        end
        default: ;
      endcase
    end
  end

  assign pop = head_valid && load_ok;

  tag_fifo #(
    .W     (2),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (issue_sel),
    .pop_i   (pop),
    .rdata_o (head_sel),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= PATH_0;
      err_q       <= 1'b0;
    end else begin
      if (pop) begin
        out_valid_q <= 1'b1;
        out_data_q  <= head_data;
        out_sel_q   <= head_sel;
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (issue_valid && is_bad_path(issue_sel)) err_q <= 1'b1;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign err       = err_q;

  // Lanes stalled by ready=0 must keep their result presented unchanged.
  a_lane0_hold: assert property (@(posedge clk) disable iff (rst)
    (r0_valid && !r0_ready) |=> (r0_valid && $stable(r0_data)));
  a_lane1_hold: assert property (@(posedge clk) disable iff (rst)
    (r1_valid && !r1_ready) |=> (r1_valid && $stable(r1_data)));
  a_lane2_hold: assert property (@(posedge clk) disable iff (rst)
    (r2_valid && !r2_ready) |=> (r2_valid && $stable(r2_data)));
  a_count_range: assert property (@(posedge clk) disable iff (rst)
    fifo_count <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_fp_path_merge.sv
module tb_fp_path_merge;
  import fp_add_pkg::*;

  localparam int unsigned W = FP_W;

  logic         clk = 1'b0;
  logic         rst;
  logic         issue_valid;
  logic [1:0]   issue_sel;
  logic         issue_ready;
  logic         r0_valid, r1_valid, r2_valid;
  logic [W-1:0] r0_data, r1_data, r2_data;
  logic         r0_ready, r1_ready, r2_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic [1:0]   out_sel;
  logic         out_ready;
  logic         err;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  fp_path_merge #(.W(W), .DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_sel   (issue_sel),
    .issue_ready (issue_ready),
    .r0_valid    (r0_valid),
    .r0_data     (r0_data),
    .r0_ready    (r0_ready),
    .r1_valid    (r1_valid),
    .r1_data     (r1_data),
    .r1_ready    (r1_ready),
    .r2_valid    (r2_valid),
    .r2_data     (r2_data),
    .r2_ready    (r2_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_sel     (out_sel),
    .out_ready   (out_ready),
    .err         (err)
  );

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Advance past the next rising edge; inputs change 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic v, input logic [1:0] s);
    issue_valid = v;
    issue_sel   = s;
  endtask

  task automatic check_out(input string tag, input logic [63:0] d, input logic [1:0] s);
    check_val({tag, "_valid"}, out_valid, 1);
    check_val({tag, "_data"},  out_data,  d);
    check_val({tag, "_sel"},   out_sel,   s);
  endtask

  task automatic check_idle_readies(input string tag);
    check_val({tag, "_r0_ready"}, r0_ready, 0);
    check_val({tag, "_r1_ready"}, r1_ready, 0);
    check_val({tag, "_r2_ready"}, r2_ready, 0);
  endtask

  initial begin
    rst = 1'b1;
    issue(0, 2'b00);
    r0_valid = 0; r1_valid = 0; r2_valid = 0;
    r0_data = '0; r1_data = '0; r2_data = '0;
    out_ready = 1'b1;
    #1;
    check_val("rst_issue_ready", issue_ready, 1);
    check_idle_readies("rst");
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_out_data", out_data, 0);
    check_val("rst_out_sel", out_sel, 0);
    check_val("rst_err", err, 0);
    step(); step();
    rst = 1'b0;

    // In-order: 00, 01, 10, each lane one cycle after its issue.
    issue(1, PATH_0);
    step();
    issue(1, PATH_1);
    r0_valid = 1; r0_data = 37'h0_0000_0001;
    #1 check_val("io_r0_ready", r0_ready, 1);
    step();
    issue(1, PATH_2);
    r0_valid = 0; r1_valid = 1; r1_data = 37'h0_0000_0002;
    #1 check_out("io_1", 1, PATH_0);
    step();
    issue(0, PATH_0);
    r1_valid = 0; r2_valid = 1; r2_data = 37'h0_0000_0003;
    #1 check_out("io_2", 2, PATH_1);
    step();
    r2_valid = 0;
    #1 check_out("io_3", 3, PATH_2);
    step();
    check_val("io_drain", out_valid, 0);

    // Out-of-order: issue 01 then 00, lane 0 answers first.
    issue(1, PATH_1);
    step();
    issue(1, PATH_0);
    step();
    issue(0, PATH_0);
    r0_valid = 1; r0_data = 37'hAA;
    #1 check_val("ooo_r0_blocked", r0_ready, 0);
    step();
    check_val("ooo_r0_still_blocked", r0_ready, 0);
    check_val("ooo_no_out", out_valid, 0);
    r1_valid = 1; r1_data = 37'hBB;
    #1 check_val("ooo_r1_ready", r1_ready, 1);
    check_val("ooo_r0_blocked2", r0_ready, 0);
    step();
    r1_valid = 0;
    #1 check_out("ooo_bb", 37'hBB, PATH_1);
    check_val("ooo_r0_now_ready", r0_ready, 1);
    step();
    r0_valid = 0;
    #1 check_out("ooo_aa", 37'hAA, PATH_0);
    step();
    check_val("ooo_drain", out_valid, 0);

    // Backpressure: 0x11 sits in the output while lane 2 holds 0x1F.
    issue(1, PATH_0);
    step();
    issue(1, PATH_2);
    step();
    issue(0, PATH_0);
    r0_valid = 1; r0_data = 37'h11;
    out_ready = 0;
    #1 check_val("bp_r0_ready", r0_ready, 1);
    step();
    r0_valid = 0; r2_valid = 1; r2_data = 37'h1F;
    for (int i = 0; i < 5; i++) begin
      #1 check_out("bp_hold", 37'h11, PATH_0);
      check_val("bp_r2_stalled", r2_ready, 0);
      step();
    end
    out_ready = 1;
    #1 check_val("bp_r2_release", r2_ready, 1);
    step();
    r2_valid = 0;
    #1 check_out("bp_1f", 37'h1F, PATH_2);
    step();
    check_val("bp_drain", out_valid, 0);

    // Full: four tags, fifth issue refused, pop frees a slot the cycle after.
    issue(1, PATH_0); step();
    issue(1, PATH_1); step();
    issue(1, PATH_2); step();
    issue(1, PATH_0); step();
    issue(1, PATH_1);
    #1 check_val("full_issue_ready", issue_ready, 0);
    step();
    check_val("full_count", dut.u_tag_fifo.count_o, 4);
    check_val("full_issue_ready2", issue_ready, 0);
    r0_valid = 1; r0_data = 37'h5;
    #1 check_val("full_pop_same_cycle", issue_ready, 0);
    step();
    issue(0, PATH_0);
    r0_valid = 0; r1_valid = 1; r1_data = 37'h6;
    #1 check_val("full_after_pop_ready", issue_ready, 1);
    check_val("full_after_pop_count", dut.u_tag_fifo.count_o, 3);
    check_out("full_5", 37'h5, PATH_0);
    step();
    r1_valid = 0; r2_valid = 1; r2_data = 37'h7;
    #1 check_out("full_6", 37'h6, PATH_1);
    step();
    r2_valid = 0; r0_valid = 1; r0_data = 37'h8;
    #1 check_out("full_7", 37'h7, PATH_2);
    step();
    r0_valid = 0;
    #1 check_out("full_8", 37'h8, PATH_0);
    check_val("full_empty_count", dut.u_tag_fifo.count_o, 0);
    check_idle_readies("full_empty");
    step();

    // Bad select: err latches, nothing pushed, err survives later traffic.
    issue(1, PATH_BAD);
    step();
    issue(0, PATH_0);
    check_val("bad_err", err, 1);
    check_val("bad_count", dut.u_tag_fifo.count_o, 0);
    issue(1, PATH_1);
    step();
    issue(0, PATH_0);
    r1_valid = 1; r1_data = 37'h9;
    #1 check_val("bad_r1_ready", r1_ready, 1);
    step();
    r1_valid = 0;
    #1 check_out("bad_9", 37'h9, PATH_1);
    check_val("bad_err_sticky", err, 1);
    step();

    // Reset mid-stream: 3 tags queued behind a valid output.
    issue(1, PATH_0); step();
    issue(1, PATH_1); step();
    issue(1, PATH_2); step();
    issue(1, PATH_0); step();
    issue(0, PATH_0);
    r0_valid = 1; r0_data = 37'hC;
    step();
    r0_valid = 0;
    #1 check_out("mid_c", 37'hC, PATH_0);
    check_val("mid_r1_ready", r1_ready, 1);
    check_val("mid_count", dut.u_tag_fifo.count_o, 3);
    rst = 1;
    #1;
    check_val("mid_rst_out_valid", out_valid, 0);
    check_val("mid_rst_out_data", out_data, 0);
    check_val("mid_rst_err", err, 0);
    check_val("mid_rst_issue_ready", issue_ready, 1);
    check_val("mid_rst_count", dut.u_tag_fifo.count_o, 0);
    check_idle_readies("mid_rst");
    step();
    rst = 0;
    issue(1, PATH_2);
    step();
    issue(0, PATH_0);
    r2_valid = 1; r2_data = 37'h1_2345_6789;
    #1 check_val("post_r2_ready", r2_ready, 1);
    step();
    r2_valid = 0;
    #1 check_out("post", 37'h1_2345_6789, PATH_2);
    check_val("post_err", err, 0);
    step();
    check_val("post_drain", out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
